game_flow_controller: RTL

Registered game-flow sequencer for the Frogger top level, generalising the two-state IDLE/RUNNING controller into a multi-life, multi-level state machine. It sits between the debounced switches, the collision detector, the LFSR and the character/obstacle blocks. It owns the game state, remaining lives, current level and the per-lane car-direction mask. It emits a single-cycle frog-respawn pulse whenever the frog must return to its base position.

---
 rtl/game_flow_controller_pkg.sv | 35 +++
 rtl/game_flow_controller_hold_timer.sv | 43 ++++
 rtl/game_flow_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/game_flow_controller_pkg.sv
// ---------------------------------------------------------------------------
// game_flow_controller_pkg
// Shared definitions for the Frogger game-flow sequencer: the state encoding
// (IDLE/RUNNING keep their historical codes 0/1), default parameter values
// and a helper that sizes the shared hold-down counter.
// ---------------------------------------------------------------------------
package game_flow_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_DYING     = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int NUM_LANES_DEF  = 4;
   localparam int NUM_LIVES_DEF  = 3;
   localparam int LIVES_BITS_DEF = 2;
   localparam int LEVEL_BITS_DEF = 4;
   localparam int MAX_LEVEL_DEF  = 9;
   localparam int DEATH_HOLD_DEF = 25000000;   // 1 s at 25 MHz
   localparam int LEVEL_HOLD_DEF = 12500000;   // 0.5 s at 25 MHz

   // Width of a counter that must hold the larger of the two hold lengths.
   // Never narrower than one bit so a hold of 1 still yields a legal vector.
   function automatic int hold_cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/game_flow_controller_hold_timer.sv
// ---------------------------------------------------------------------------
// game_flow_controller_hold_timer
// Load-and-count-down timer shared by the DYING and LEVEL_UP states.
//   i_Clk        clock
//   i_Reset      asynchronous active-high reset (counter -> 0)
//   i_Load       load i_Load_Value this cycle
//   i_Load_Value value to load (hold length minus one)
//   o_Done       counter has reached zero
// The counter stops at zero rather than wrapping.
// ---------------------------------------------------------------------------
module game_flow_controller_hold_timer #(
   parameter int CNT_W = 4
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Load,
   input  logic [CNT_W-1:0] i_Load_Value,
   output logic             o_Done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_Load) begin
         count_d = i_Load_Value;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_Done = (count_q == '0);

endmodule

// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller
// Multi-life, multi-level game-flow sequencer for the Frogger top level.
//   i_Clk / i_Reset   25 MHz clock, asynchronous active-high reset
//   i_Start           start request (level, edge-detected here)
//   i_Has_Collided    frog/car overlap (level)
//   i_Level_Up        frog reached far bank (level)
//   i_LFSR_Data       pseudo-random source for the lane direction mask
//   o_Game_Active     high only while RUNNING
//   o_State           encoded current state
//   o_Lives/o_Level   remaining lives / 0-based level
//   o_Reverse         per-lane direction mask, never zero
//   o_Frog_Reset      one-cycle respawn pulse on every entry to RUNNING
//   o_Game_Over       high in GAME_OVER
// All outputs are registered; each is computed from the next state so it
// changes on the same edge as the state itself.
// ---------------------------------------------------------------------------
module game_flow_controller
   import game_flow_controller_pkg::*;
#(
   parameter int NUM_LANES  = NUM_LANES_DEF,
   parameter int NUM_LIVES  = NUM_LIVES_DEF,
   parameter int LIVES_BITS = LIVES_BITS_DEF,
   parameter int LEVEL_BITS = LEVEL_BITS_DEF,
   parameter int MAX_LEVEL  = MAX_LEVEL_DEF,
   parameter int DEATH_HOLD = DEATH_HOLD_DEF,
   parameter int LEVEL_HOLD = LEVEL_HOLD_DEF
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Start,
   input  logic                  i_Has_Collided,
   input  logic                  i_Level_Up,
   input  logic [NUM_LANES-1:0]  i_LFSR_Data,
   output logic                  o_Game_Active,
   output logic [2:0]            o_State,
   output logic [LIVES_BITS-1:0] o_Lives,
   output logic [LEVEL_BITS-1:0] o_Level,
   output logic [NUM_LANES-1:0]  o_Reverse,
   output logic                  o_Frog_Reset,
   output logic                  o_Game_Over
);

   localparam int CNT_W = hold_cnt_width(DEATH_HOLD, LEVEL_HOLD);

   state_t                state_q,       state_d;
   logic                  start_q;
   logic [LIVES_BITS-1:0] lives_q,       lives_d;
   logic [LEVEL_BITS-1:0] level_q,       level_d;
   logic [NUM_LANES-1:0]  reverse_q,     reverse_d;
   logic                  frog_reset_q,  frog_reset_d;
   logic                  game_active_q, game_active_d;
   logic                  game_over_q,   game_over_d;

   logic                  start_edge;
   logic [NUM_LANES-1:0]  lfsr_mask;
   logic                  hold_load;
   logic [CNT_W-1:0]      hold_value;
   logic                  hold_done;

   // start_q resets high, so a switch held through reset produces no edge.
   assign start_edge = i_Start & ~start_q;

   // An all-zero mask would leave every lane in the same direction; use lane 0.
   assign lfsr_mask = (i_LFSR_Data == '0) ? NUM_LANES'(1) : i_LFSR_Data;

   game_flow_controller_hold_timer #(
      .CNT_W(CNT_W)
   ) u_hold_timer (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Load      (hold_load),
      .i_Load_Value(hold_value),
      .o_Done      (hold_done)
   );

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      level_d    = level_q;
      reverse_d  = reverse_q;
      hold_load  = 1'b0;
      hold_value = '0;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d   = ST_RUNNING;
               lives_d   = LIVES_BITS'(NUM_LIVES);
               level_d   = '0;
               reverse_d = lfsr_mask;
            end
         end
         ST_RUNNING: begin
            // Collision wins over a simultaneous level-up.
            if (i_Has_Collided) begin
               if (lives_q > LIVES_BITS'(1)) begin
                  lives_d    = lives_q - LIVES_BITS'(1);
                  state_d    = ST_DYING;
                  hold_load  = 1'b1;
                  hold_value = CNT_W'(DEATH_HOLD - 1);
               end else begin
                  lives_d = '0;
                  state_d = ST_GAME_OVER;
               end
            end else if (i_Level_Up) begin
               state_d    = ST_LEVEL_UP;
               reverse_d  = lfsr_mask;
               hold_load  = 1'b1;
               hold_value = CNT_W'(LEVEL_HOLD - 1);
               if (level_q < LEVEL_BITS'(MAX_LEVEL)) begin
                  level_d = level_q + LEVEL_BITS'(1);
               end
            end
         end
         // Both hold states ignore every input until the timer expires.
         ST_DYING, ST_LEVEL_UP: begin
            if (hold_done) begin
               state_d = ST_RUNNING;
            end
         end
         ST_GAME_OVER: begin
            if (start_edge) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      frog_reset_d  = (state_d == ST_RUNNING) && (state_q != ST_RUNNING);
      game_active_d = (state_d == ST_RUNNING);
      game_over_d   = (state_d == ST_GAME_OVER);
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q       <= ST_IDLE;
         start_q       <= 1'b1;
         lives_q       <= '0;
         level_q       <= '0;
         reverse_q     <= NUM_LANES'(1);
         frog_reset_q  <= 1'b0;
         game_active_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= i_Start;
         lives_q       <= lives_d;
         level_q       <= level_d;
         reverse_q     <= reverse_d;
         frog_reset_q  <= frog_reset_d;
         game_active_q <= game_active_d;
         game_over_q   <= game_over_d;
      end
   end

   assign o_State       = state_q;
   assign o_Lives       = lives_q;
   assign o_Level       = level_q;
   assign o_Reverse     = reverse_q;
   assign o_Frog_Reset  = frog_reset_q;
   assign o_Game_Active = game_active_q;
   assign o_Game_Over   = game_over_q;

endmodule
